// File: rtl/text_console_pkg.sv
// rtl/text_console_pkg.sv - shared constants, state encoding and helpers for text_console
// Screen geometry defaults, control codes and the controller state set.
package console_pkg;

  localparam int COLS_DEF     = 80;
  localparam int ROWS_DEF     = 25;
  localparam int ROW_BYTES    = 2 * COLS_DEF;
  localparam int SCREEN_BYTES = 2 * COLS_DEF * ROWS_DEF;

  localparam logic [7:0] CC_BS    = 8'h08;
  localparam logic [7:0] CC_LF    = 8'h0A;
  localparam logic [7:0] CC_FF    = 8'h0C;
  localparam logic [7:0] CC_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE, WCHR, WATTR, CTRL, SCROLL_RD, SCROLL_WR, FILL, CLEAR
  } state_e;

  typedef enum logic {MV_COPY, MV_FILL} mv_mode_e;

  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == CC_BS) || (b == CC_LF) || (b == CC_FF) || (b == CC_CR);
  endfunction

  // Byte address of the character half of cell (x, y).
  function automatic logic [12:0] cell_addr(input logic [7:0] x, input logic [7:0] y,
                                            input int cols);
    logic [12:0] idx;
    idx = 13'(x) + 13'(y) * 13'(cols);
    return idx << 1;
  endfunction

endpackage

// File: rtl/text_console_vram_mover.sv
// rtl/text_console_vram_mover.sv - VRAM copy/fill engine used for scroll, row fill and clear
// Copy alternates a read cycle at src+i with a write of the returned byte to dst+i.
module vram_mover
  import console_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  mv_mode_e    mode_i,
  input  logic [12:0] src_i,
  input  logic [12:0] dst_i,
  input  logic [11:0] len_i,
  input  logic [7:0]  fill_char_i,
  input  logic [7:0]  fill_attr_i,
  input  logic [7:0]  vram_rdata_i,
  output logic        done_o,
  output logic [12:0] vram_address_o,
  output logic [7:0]  vram_wdata_o,
  output logic        vram_we_o
);

  logic        active_q;
  logic        wr_q;
  mv_mode_e    mode_q;
  logic [11:0] cnt_q;
  logic [11:0] last_q;
  logic [12:0] src_q;
  logic [12:0] dst_q;
  logic [7:0]  char_q;
  logic [7:0]  attr_q;

  logic        rd_cycle;
  logic        wr_cycle;
  logic [12:0] rd_addr;
  logic [12:0] wr_addr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      wr_q     <= 1'b0;
      mode_q   <= MV_COPY;
      cnt_q    <= '0;
      last_q   <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      char_q   <= '0;
      attr_q   <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      wr_q     <= 1'b0;
      mode_q   <= mode_i;
      cnt_q    <= '0;
      last_q   <= len_i - 12'd1;
      src_q    <= src_i;
      dst_q    <= dst_i;
      char_q   <= fill_char_i;
      attr_q   <= fill_attr_i;
    end else if (active_q) begin
      if (rd_cycle) begin
        wr_q <= 1'b1;
      end else begin
        wr_q <= 1'b0;
        if (cnt_q == last_q) active_q <= 1'b0;
        else cnt_q <= cnt_q + 12'd1;
      end
    end
  end

  assign rd_cycle = active_q && (mode_q == MV_COPY) && !wr_q;
  assign wr_cycle = active_q && !rd_cycle;
  assign rd_addr  = src_q + {1'b0, cnt_q};
  assign wr_addr  = dst_q + {1'b0, cnt_q};
  assign done_o   = wr_cycle && (cnt_q == last_q);

  always_comb begin
    vram_address_o = '0;
    vram_wdata_o   = '0;
    vram_we_o      = 1'b0;
    if (rd_cycle) begin
      vram_address_o = rd_addr;
    end else if (wr_cycle) begin
      vram_address_o = wr_addr;
      vram_we_o      = 1'b1;
      if (mode_q == MV_COPY) vram_wdata_o = vram_rdata_i;
      else vram_wdata_o = wr_addr[0] ? attr_q : char_q;
    end
  end

endmodule

// File: rtl/text_console.sv
// rtl/text_console.sv - byte-stream console writing char/attr cells into text VRAM
// Interprets CR/LF/BS/FF and scrolls by copying VRAM through vram_mover.
module text_console
  import console_pkg::*;
#(
  parameter int         COLS         = COLS_DEF,
  parameter int         ROWS         = ROWS_DEF,
  parameter logic [7:0] DEFAULT_ATTR = 8'h07
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [7:0]  attr_in,
  input  logic        attr_we,
  output logic [12:0] vram_address,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  cursor_x,
  output logic [7:0]  cursor_y,
  output logic        busy
);

  localparam logic [12:0] ROW_B  = 13'(2 * COLS);
  localparam logic [12:0] SCR_B  = 13'(2 * COLS * ROWS);
  localparam logic [7:0]  LAST_X = 8'(COLS - 1);
  localparam logic [7:0]  LAST_Y = 8'(ROWS - 1);

  state_e      state_q;
  logic [7:0]  x_q;
  logic [7:0]  y_q;
  logic [7:0]  attr_q;
  logic [7:0]  ch_q;
  logic [7:0]  att_q;
  logic [12:0] addr_q;
  logic        bs_q;

  logic        mv_start;
  mv_mode_e    mv_mode;
  logic [12:0] mv_src;
  logic [12:0] mv_dst;
  logic [11:0] mv_len;
  logic        mv_done;
  logic [12:0] mv_address;
  logic [7:0]  mv_wdata;
  logic        mv_we;

  assign char_ready = (state_q == IDLE) && !RESET;
  assign busy       = !char_ready;
  assign cursor_x   = x_q;
  assign cursor_y   = y_q;

  // Mover is launched one cycle ahead so it is active exactly while the FSM sits in its states.
  always_comb begin
    mv_start = 1'b0;
    mv_mode  = MV_COPY;
    mv_src   = ROW_B;
    mv_dst   = '0;
    mv_len   = 12'(SCR_B - ROW_B);
    case (state_q)
      CTRL: begin
        if (ch_q == CC_LF && y_q == LAST_Y) begin
          mv_start = 1'b1;
        end else if (ch_q == CC_FF) begin
          mv_start = 1'b1;
          mv_mode  = MV_FILL;
          mv_len   = 12'(SCR_B);
        end
      end
      WATTR: mv_start = !bs_q && (x_q == LAST_X) && (y_q == LAST_Y);
      SCROLL_WR: begin
        if (mv_done) begin
          mv_start = 1'b1;
          mv_mode  = MV_FILL;
          mv_dst   = SCR_B - ROW_B;
          mv_len   = 12'(ROW_B);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    vram_address = '0;
    vram_wdata   = '0;
    vram_we      = 1'b0;
    case (state_q)
      WCHR: begin
        vram_address = addr_q;
        vram_wdata   = ch_q;
        vram_we      = 1'b1;
      end
      WATTR: begin
        vram_address = addr_q + 13'd1;
        vram_wdata   = att_q;
        vram_we      = 1'b1;
      end
      SCROLL_RD, SCROLL_WR, FILL, CLEAR: begin
        vram_address = mv_address;
        vram_wdata   = mv_wdata;
        vram_we      = mv_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      attr_q  <= DEFAULT_ATTR;
      ch_q    <= '0;
      att_q   <= '0;
      addr_q  <= '0;
      bs_q    <= 1'b0;
    end else begin
      if (attr_we) attr_q <= attr_in;
      case (state_q)
        IDLE: begin
          if (char_valid) begin
            ch_q  <= char_data;
            att_q <= attr_q;
            bs_q  <= 1'b0;
            if (!is_ctrl(char_data)) begin
              addr_q  <= cell_addr(x_q, y_q, COLS);
              state_q <= WCHR;
            end else if (char_data == CC_BS && x_q != 8'd0) begin
              addr_q  <= cell_addr(x_q - 8'd1, y_q, COLS);
              ch_q    <= CH_SPACE;
              bs_q    <= 1'b1;
              state_q <= WCHR;
            end else begin
              state_q <= CTRL;
            end
          end
        end
        WCHR: state_q <= WATTR;
        WATTR: begin
          state_q <= IDLE;
          if (bs_q) begin
            x_q <= x_q - 8'd1;
          end else if (x_q != LAST_X) begin
            x_q <= x_q + 8'd1;
          end else if (y_q != LAST_Y) begin
            x_q <= '0;
            y_q <= y_q + 8'd1;
          end else begin
            state_q <= SCROLL_RD;
          end
        end
        CTRL: begin
          state_q <= IDLE;
          case (ch_q)
            CC_CR: x_q <= '0;
            CC_LF: begin
              if (y_q == LAST_Y) state_q <= SCROLL_RD;
              else y_q <= y_q + 8'd1;
            end
            CC_FF:   state_q <= CLEAR;
            default: ;
          endcase
        end
        SCROLL_RD: state_q <= SCROLL_WR;
        SCROLL_WR: state_q <= mv_done ? FILL : SCROLL_RD;
        FILL: begin
          if (mv_done) begin
            if (!is_ctrl(ch_q)) x_q <= '0;
            state_q <= IDLE;
          end
        end
        CLEAR: begin
          if (mv_done) begin
            x_q     <= '0;
            y_q     <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  vram_mover u_mover (
    .clk_i          (CLOCK),
    .rst_i          (RESET),
    .start_i        (mv_start),
    .mode_i         (mv_mode),
    .src_i          (mv_src),
    .dst_i          (mv_dst),
    .len_i          (mv_len),
    .fill_char_i    (CH_SPACE),
    .fill_attr_i    (att_q),
    .vram_rdata_i   (vram_rdata),
    .done_o         (mv_done),
    .vram_address_o (mv_address),
    .vram_wdata_o   (mv_wdata),
    .vram_we_o      (mv_we)
  );

endmodule

// File: tb/tb_text_console.sv
// tb/tb_text_console.sv - self-checking bench for text_console
// Screen model plus directed byte sequences with literal expectations.
module tb_text_console;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  char_data = '0;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [7:0]  attr_in = '0;
  logic        attr_we = 1'b0;
  logic [12:0] vram_address;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [7:0]  vram_rdata = '0;
  logic [7:0]  cursor_x;
  logic [7:0]  cursor_y;
  logic        busy;

  text_console dut (
    .CLOCK(CLOCK), .RESET(RESET), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .attr_in(attr_in), .attr_we(attr_we),
    .vram_address(vram_address), .vram_wdata(vram_wdata), .vram_we(vram_we),
    .vram_rdata(vram_rdata), .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {int c; int a; int d;} wr_t;

  logic [7:0] vram [0:8191];
  wr_t        wq[$];
  wr_t        wrec;
  int         cyc = 0;
  logic       pl_req = 1'b0;
  logic       pl_pal = 1'b0;
  int         pl_lo = 0;
  int         pl_hi = 0;
  logic [7:0] pl_val = '0;

  always @(posedge CLOCK) begin
    if (pl_req) begin
      for (int i = pl_lo; i <= pl_hi; i++) vram[i] <= pl_pal ? (8'(i) ^ 8'h5A) : pl_val;
    end else if (vram_we) begin
      vram[vram_address] <= vram_wdata;
      wrec.c = cyc;
      wrec.a = int'(vram_address);
      wrec.d = int'(vram_wdata);
      wq.push_back(wrec);
    end
    vram_rdata <= vram[vram_address];
    cyc <= cyc + 1;
  end

  logic [7:0] mm [0:3999];
  int         mx = 0, my = 0, px = 0, py = 0;
  logic [7:0] cur_attr = 8'h07;
  int         checks = 0, errors = 0;
  int         pc_bad = 0;
  logic       en = 1'b0;
  int         hs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_lf(input logic [7:0] att);
    if (my < 24) my++;
    else begin
      for (int i = 0; i < 3840; i++) mm[i] = mm[i + 160];
      for (int i = 3840; i < 4000; i++) mm[i] = (i % 2 == 1) ? att : 8'h20;
    end
  endtask

  task automatic model_apply(input logic [7:0] b, input logic [7:0] att);
    px = mx;
    py = my;
    case (b)
      8'h0D: mx = 0;
      8'h0A: model_lf(att);
      8'h08: if (mx > 0) begin
        mx--;
        mm[2*(mx+80*my)]   = 8'h20;
        mm[2*(mx+80*my)+1] = att;
      end
      8'h0C: begin
        for (int i = 0; i < 4000; i++) mm[i] = (i % 2 == 1) ? att : 8'h20;
        mx = 0;
        my = 0;
      end
      default: begin
        mm[2*(mx+80*my)]   = b;
        mm[2*(mx+80*my)+1] = att;
        mx++;
        if (mx == 80) begin
          mx = 0;
          model_lf(att);
        end
      end
    endcase
  endtask

  // Per-cycle checks: handshake pair consistency, address range, cursor steady until op end.
  always @(negedge CLOCK) begin
    if (en && !RESET) begin
      if (busy !== ~char_ready) pc_bad++;
      else if (vram_address >= 13'd4000) pc_bad++;
      else if (char_ready && (cursor_x !== 8'(mx) || cursor_y !== 8'(my))) pc_bad++;
      else if (!char_ready && (cursor_x !== 8'(px) || cursor_y !== 8'(py))) pc_bad++;
    end
  end

  task automatic preload(input int lo, input int hi, input logic [7:0] v, input logic pal);
    pl_lo = lo; pl_hi = hi; pl_val = v; pl_pal = pal; pl_req = 1'b1;
    @(negedge CLOCK);
    pl_req = 1'b0;
    if (!pal) for (int i = lo; i <= hi; i++) mm[i] = v;
  endtask

  task automatic start_byte(input logic [7:0] b);
    int n = 0;
    while (char_ready !== 1'b1 && n < 20000) begin @(negedge CLOCK); n++; end
    if (char_ready !== 1'b1) chk("ready_before_send", char_ready, 1);
    wq.delete();
    char_data = b;
    char_valid = 1'b1;
    hs = cyc;
    @(posedge CLOCK);
    model_apply(b, cur_attr);
    @(negedge CLOCK);
    char_valid = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    int n = 0;
    while (char_ready !== 1'b1 && n < 20000) begin @(negedge CLOCK); n++; end
    if (char_ready !== 1'b1) chk("ready_timeout", 0, 1);
    lat = cyc - hs;
  endtask

  task automatic send(input logic [7:0] b, output int lat);
    start_byte(b);
    wait_ready(lat);
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    int l;
    for (int i = 0; i < n; i++) send(b, l);
  endtask

  task automatic set_attr(input logic [7:0] a);
    attr_in = a;
    attr_we = 1'b1;
    @(negedge CLOCK);
    attr_we = 1'b0;
    cur_attr = a;
  endtask

  task automatic chk_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 4000; i++) if (vram[i] !== mm[i]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic chk_pal(input string name);
    int bad = 0;
    for (int i = 4000; i < 8192; i++) if (vram[i] !== (8'(i) ^ 8'h5A)) bad++;
    chk(name, bad, 0);
  endtask

  task automatic chk_cur(input string name, input int x, input int y);
    chk({name, "_x"}, cursor_x, x);
    chk({name, "_y"}, cursor_y, y);
  endtask

  initial begin
    int lat;
    int bad;
    @(negedge CLOCK);
    preload(0, 3999, 8'h00, 1'b0);
    preload(4000, 8191, 8'h00, 1'b1);
    @(negedge CLOCK);
    chk("rst_ready", char_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_we", vram_we, 0);
    chk("rst_addr", vram_address, 0);
    chk("rst_wdata", vram_wdata, 0);
    chk_cur("rst_cur", 0, 0);
    RESET = 1'b0;
    @(negedge CLOCK);
    chk("ready_after_reset", char_ready, 1);
    en = 1'b1;

    set_attr(8'h1E);
    send(8'h41, lat);
    chk("A_lat", lat, 3);
    chk("A_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("A_w0_cyc", wq[0].c - hs, 1);
      chk("A_w0_addr", wq[0].a, 0);
      chk("A_w0_data", wq[0].d, 8'h41);
      chk("A_w1_cyc", wq[1].c - hs, 2);
      chk("A_w1_addr", wq[1].a, 1);
      chk("A_w1_data", wq[1].d, 8'h1E);
    end
    chk_cur("A_cur", 1, 0);
    chk_mem("A_mem");

    send(8'h0D, lat);
    chk("cr_lat", lat, 2);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      send(8'h78, lat);
      if (lat != 3) bad++;
    end
    chk("row80_lat", bad, 0);
    chk("row80_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("row80_last_c", wq[0].a, 158);
      chk("row80_last_a", wq[1].a, 159);
    end
    chk_cur("row80_cur", 0, 1);
    chk_mem("row80_mem");

    send_n(8'h0A, 23);
    send_n(8'h78, 5);
    chk_cur("pos_cur", 5, 24);
    preload(160, 319, 8'h42, 1'b0);
    preload(3840, 3999, 8'h43, 1'b0);
    send(8'h0A, lat);
    chk("scroll_lat", lat, 7842);
    chk("scroll_nwr", wq.size(), 4000);
    if (wq.size() == 4000) begin
      chk("scroll_first_wr", wq[0].c - hs, 3);
      chk("scroll_last_wr", wq[3999].c - hs, 7841);
      chk("scroll_last_addr", wq[3999].a, 3999);
    end
    chk("scroll_b0", vram[0], 8'h42);
    chk("scroll_b3680", vram[3680], 8'h43);
    chk("scroll_b3839", vram[3839], 8'h43);
    chk("scroll_b3840", vram[3840], 8'h20);
    chk("scroll_b3841", vram[3841], 8'h1E);
    chk_cur("scroll_cur", 5, 24);
    chk_mem("scroll_mem");

    set_attr(8'h2A);
    start_byte(8'h0C);
    repeat (100) @(negedge CLOCK);
    attr_in = 8'h4F;
    attr_we = 1'b1;
    @(negedge CLOCK);
    attr_we = 1'b0;
    cur_attr = 8'h4F;
    wait_ready(lat);
    chk("clear_lat", lat, 4002);
    chk("clear_nwr", wq.size(), 4000);
    chk("clear_b0", vram[0], 8'h20);
    chk("clear_b1", vram[1], 8'h2A);
    chk("clear_b3999", vram[3999], 8'h2A);
    chk_cur("clear_cur", 0, 0);
    chk_mem("clear_mem");

    send_n(8'h0A, 3);
    send_n(8'h78, 37);
    send(8'h0D, lat);
    chk("cr_lat2", lat, 2);
    chk("cr_nwr", wq.size(), 0);
    chk_cur("cr_cur", 0, 3);
    send(8'h08, lat);
    chk("bs0_lat", lat, 2);
    chk("bs0_nwr", wq.size(), 0);
    chk_cur("bs0_cur", 0, 3);
    send_n(8'h78, 4);
    send(8'h08, lat);
    chk("bs_lat", lat, 3);
    chk("bs_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("bs_w0_addr", wq[0].a, 486);
      chk("bs_w0_data", wq[0].d, 8'h20);
      chk("bs_w1_addr", wq[1].a, 487);
      chk("bs_w1_data", wq[1].d, 8'h4F);
    end
    chk_cur("bs_cur", 3, 3);
    chk_mem("bs_mem");

    send_n(8'h0A, 21);
    send_n(8'h78, 76);
    chk_cur("wrap_pre_cur", 79, 24);
    send(8'h5A, lat);
    chk("wrap_lat", lat, 7843);
    chk_cur("wrap_cur", 0, 24);
    chk("wrap_b3838", vram[3838], 8'h5A);
    chk_mem("wrap_mem");
    chk_pal("palette_font");
    chk("per_cycle", pc_bad, 0);

    start_byte(8'h0A);
    repeat (999) @(negedge CLOCK);
    en = 1'b0;
    RESET = 1'b1;
    @(negedge CLOCK);
    chk("abort_we", vram_we, 0);
    chk_cur("abort_cur", 0, 0);
    chk("abort_ready", char_ready, 0);
    RESET = 1'b0;
    @(negedge CLOCK);
    chk("abort_ready_after", char_ready, 1);
    chk("abort_busy_after", busy, 0);
    chk_pal("palette_font_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
